// File: rtl/sseg_pkg.sv
`default_nettype none
// sseg_pkg: shared constants, action encoding and hex-to-segment decode
// for the seven-segment digit editor. Rev 1.0

package sseg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NUM_BTNS   = 4;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_LOAD  = 3'd1,
    ACT_UP    = 3'd2,
    ACT_DOWN  = 3'd3,
    ACT_LEFT  = 3'd4,
    ACT_RIGHT = 3'd5
  } action_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off (bit 7 = 1).
  function automatic logic [7:0] hex_to_sseg(input logic [3:0] hex);
    logic [7:0] seg;
    case (hex)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// btn_debounce: two-flop synchronizer, stable-window debouncer and
// registered rising-edge press pulse for one push-button. Rev 1.0

module btn_debounce #(
  parameter int DB_CNT_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = '1;

  logic                sync_meta;
  logic                sync_out;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;

      // Any return to agreement restarts the stable window from zero.
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sseg_digit_editor.sv
`default_nettype none
// sseg_digit_editor: 8-digit hex value editor driven by debounced buttons
// and an MMIO load port, feeding the seven-segment multiplexer. Rev 1.0

module sseg_digit_editor
  import sseg_pkg::*;
#(
  parameter int DB_CNT_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [7:0]  dp,
  output logic [31:0] value,
  output logic [2:0]  active_segment,
  output logic        changed,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic [7:0]  in3,
  output logic [7:0]  in4,
  output logic [7:0]  in5,
  output logic [7:0]  in6,
  output logic [7:0]  in7
);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] unused_btn_level;

  assign raw_btn[BTN_L] = btn_l;
  assign raw_btn[BTN_R] = btn_r;
  assign raw_btn[BTN_U] = btn_u;
  assign raw_btn[BTN_D] = btn_d;

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    btn_debounce #(
      .DB_CNT_W (DB_CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_btn[b]),
      .level (unused_btn_level[b]),
      .rise  (press[b])
    );
  end

  action_t     action;
  logic [2:0]  cursor;
  logic [4:0]  digit_lsb;
  logic [3:0]  cur_digit;
  logic [31:0] value_next;

  // One action per cycle; lower-priority presses in the same cycle are lost.
  always_comb begin
    action = ACT_NONE;
    if (load)              action = ACT_LOAD;
    else if (press[BTN_U]) action = ACT_UP;
    else if (press[BTN_D]) action = ACT_DOWN;
    else if (press[BTN_L]) action = ACT_LEFT;
    else if (press[BTN_R]) action = ACT_RIGHT;
  end

  assign digit_lsb = {cursor, 2'b00};
  assign cur_digit = value[digit_lsb +: 4];

  always_comb begin
    value_next = value;
    case (action)
      ACT_LOAD: value_next = load_data;
      ACT_UP:   value_next[digit_lsb +: 4] = cur_digit + 4'd1;
      ACT_DOWN: value_next[digit_lsb +: 4] = cur_digit - 4'd1;
      default:  value_next = value;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value   <= '0;
      cursor  <= '0;
      changed <= 1'b0;
    end else begin
      value   <= value_next;
      changed <= (action == ACT_LOAD) || (action == ACT_UP) || (action == ACT_DOWN);
      case (action)
        ACT_LEFT:  cursor <= cursor + 3'd1;
        ACT_RIGHT: cursor <= cursor - 3'd1;
        default:   cursor <= cursor;
      endcase
    end
  end

  assign active_segment = cursor;

  logic [7:0] seg [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign seg[i] = hex_to_sseg(value[4*i +: 4]) & {~dp[i], 7'h7F};
  end

  assign in0 = seg[0];
  assign in1 = seg[1];
  assign in2 = seg[2];
  assign in3 = seg[3];
  assign in4 = seg[4];
  assign in5 = seg[5];
  assign in6 = seg[6];
  assign in7 = seg[7];

endmodule

`default_nettype wire

// File: doc/sseg_digit_editor.md
# sseg_digit_editor

Upstream feeder for the 8-digit seven-segment multiplexer. It holds a 32-bit value as eight hex digits and debounces four push-buttons. Left/right move an edit cursor, and up/down increment or decrement the digit under the cursor. It drives the eight active-low segment patterns and the 3-bit cursor index (`active_segment`) that the multiplexer uses to blink the selected digit. An MMIO load port allows software to preset the value.

## Interface
- `DB_CNT_W`, default 20: debounce counter width. The stable window is 2^DB_CNT_W cycles, about 10.5 ms at 100 MHz.
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `btn_l`, `btn_r`, `btn_u`, `btn_d`  in  1 each  raw asynchronous push-buttons, active-high
- `load`  in  1  one-cycle strobe; copy `load_data` into value
- `load_data`  in  32  value to load
- `dp`  in  8  decimal-point enables, active-high, bit i → digit i
- `value`  out  32  current value; digit i = `value[4i+3:4i]`
- `active_segment`  out  3  cursor digit index, 0 = rightmost
- `changed`  out  1  one-cycle pulse, coincident with any value update
- `in0`..`in7`  out  8 each  active-low patterns {dp,g,f,e,d,c,b,a} for digits 0..7

## Operation
- **Reset values:**
  - `value` = 0x0000_0000, cursor = 0, `changed` = 0.
  - All debounced states = 0 and all debounce counters = 0.
  - Hence `in0`..`in7` = 0xC0 when `dp` = 0.
- **Per-button pipeline:**
  - Two-flop synchronizer.
  - Debounce counter increments while the synchronized input ≠ the debounced state. It clears to 0 whenever they are equal.
  - When the counter is at 2^DB_CNT_W−1 and the inputs still differ, the debounced state toggles and the counter clears.
  - A rising edge of the debounced state produces a one-cycle press pulse. Releases generate no action.
- **Actions:** one per cycle, priority load > up > down > left > right. Lower-priority pulses in the same cycle are dropped, not queued.
  - up: digit[cursor] ← digit[cursor]+1 mod 16. No carry into neighbouring digits.
  - down: digit[cursor] ← digit[cursor]−1 mod 16. No borrow.
  - left: cursor ← cursor+1, wrapping 7→0.
  - right: cursor ← cursor−1, wrapping 0→7.
  - load: value ← `load_data`. The cursor is unchanged.
- **`changed`:** asserted on the edge where `value` is written by up, down or load. It is asserted even if the new value equals the old one. It is never asserted for cursor moves.
- **Segment decode:** combinational from `value` and `dp`.
  - Hex map 0..F → C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
  - When `dp[i]` = 1, bit 7 of `in_i` is cleared.
- `active_segment` = cursor register, driven directly.
- **Reset mid-debounce:** the counter and state clear immediately. A held button must then complete a full stable window before it produces a press.

## Timing
- Raw button rising at sample edge 0 and held:
  - synchronizer output at edge 2;
  - debounced state at edge 2^DB_CNT_W+2;
  - press pulse at edge 2^DB_CNT_W+3;
  - `value`/cursor/`changed` at edge 2^DB_CNT_W+4.
- Glitch rule: a raw pulse shorter than 2^DB_CNT_W cycles, after synchronization, produces no press.
- `load`: `value` and `changed` are updated on the edge after the strobe, giving 1-cycle latency.
- `in_i` follows `value` and `dp` in the same cycle.
- Holding a button produces exactly one action. There is no auto-repeat.

## Structure
- **Package `sseg_pkg`:**
  - function `hex_to_sseg(logic [3:0]) → logic [7:0]`, active-low, dp bit = 1;
  - `localparam NUM_DIGITS = 8`;
  - button index constants BTN_L/R/U/D.
- **Sub-module `btn_debounce`** (parameter DB_CNT_W):
  - ports: clk, reset, raw in, debounced level out, rise pulse out;
  - instantiated four times.
- **Top:** action priority logic, value and cursor registers, eight decoder instances via `generate`.

## Test plan
(Run with `DB_CNT_W` = 2; press latency is 8 cycles.)
- **Reset:** release reset → `value`=0, `active_segment`=0, all `in_i`=0xC0, `changed`=0.
- **Up press at digit 0:** `btn_u` held 20 cycles from value 0 → at edge 8 `value`=0x0000_0001, `in0`=0xF9, `changed` high exactly 1 cycle. Continued holding causes no further change.
- **Wrap-around:**
  - `load` 0x0000_000F, then up → `value`=0x0000_0000, with no carry to digit 1.
  - Then down → 0x0000_000F.
  - Right from cursor 0 → `active_segment`=7.
- **Cursor edit:** left ×3, then up → `active_segment`=3, `value`=0x0000_1000, `in3`=0xF9.
- **Glitch and simultaneous events:**
  - A 3-cycle `btn_u` pulse → no change.
  - `load`=0xDEAD_BEEF in the same cycle as an up press pulse → `value`=0xDEAD_BEEF, up dropped.
  - `dp`=0x01 → `in0`=0x0E.
- **Reset mid-operation:** assert `reset` with `btn_u` held at cycle 3 of debounce → after release, the button must stay held 8 more cycles before `value` increments once.
